// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive path and the transmitter.
//   uart_state_e : receiver frame states.
//   os_cycles()  : clocks per oversample tick, rounded to nearest, minimum 1.
//   mid_tick()   : oversample tick at which a bit is sampled.
//   parity_bit() : parity bit for a data byte (even: XOR of data, odd: inverted).
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

  function automatic int os_cycles(input int clk_freq_hz, input int baudrate, input int oversample);
    longint div;
    longint q;
    div = longint'(baudrate) * longint'(oversample);
    q   = (longint'(clk_freq_hz) + div / 2) / div;
    return (q < 1) ? 1 : int'(q);
  endfunction

  function automatic int mid_tick(input int oversample);
    return oversample / 2;
  endfunction

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic even);
    return even ? ^data : ~^data;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running oversample tick generator shared by UART RX and TX.
//   Emits a 1-cycle pulse every os_cycles(CLK_FREQ_HZ, BAUDRATE, OVERSAMPLE) clocks.
// Ports:
//   clk  in  1  clock
//   rst  in  1  synchronous reset, active-low
//   tick out 1  oversample tick pulse
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUDRATE    = 9600,
  parameter int OVERSAMPLE  = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int OS_CYCLES = os_cycles(CLK_FREQ_HZ, BAUDRATE, OVERSAMPLE);
  localparam int CW        = (OS_CYCLES > 1) ? $clog2(OS_CYCLES) : 1;

  logic [CW-1:0] cnt_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (cnt_q == CW'(OS_CYCLES - 1)) begin
      cnt_q <= '0;
      tick  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + CW'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 / 8P1 UART receive stage, LSB first, oversampled.
//   Build option: define UART_RX_MAJORITY_EN to decide every bit by a 2-of-3
//   majority of samples at ticks MID-1, MID, MID+1; otherwise one sample at MID.
// Ports:
//   clk    in  1  clock
//   rst    in  1  synchronous reset, active-low
//   rx     in  1  asynchronous serial line, idle high
//   pen    in  1  parity enable, captured at start detection
//   peven  in  1  1 = even parity, 0 = odd, captured at start detection
//   dout   out 8  last received byte, held until next valid
//   valid  out 1  1-cycle strobe; dout/perr/ferr update in the same cycle
//   perr   out 1  parity mismatch of the frame at dout (0 when parity off)
//   ferr   out 1  stop bit sampled low for the frame at dout
//   busy   out 1  high from start detection until the FSM returns to idle
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUDRATE    = 9600,
  parameter int OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       pen,
  input  logic       peven,
  output logic [7:0] dout,
  output logic       valid,
  output logic       perr,
  output logic       ferr,
  output logic       busy
);

  localparam int MID = mid_tick(OVERSAMPLE);
  localparam int CW  = $clog2(OVERSAMPLE);

  logic          tick;
  logic          sync_q;
  logic          rxs;
  logic [CW-1:0] cnt_q;
  uart_state_e   state_q, state_d;
  logic          start_det;
  logic          frame_end;
  logic          sample_stb;
  logic          sample_bit;
  logic [2:0]    bit_idx_q;
  logic [7:0]    data_q;
  logic          pen_q;
  logic          peven_q;
  logic          perr_n_q;
  logic          stop_q;
  logic          done_q;

  uart_baud_tick #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUDRATE   (BAUDRATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Two-flop synchroniser, reset to the idle line level so reset never looks like a start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= 1'b1;
      rxs    <= 1'b1;
    end else begin
      sync_q <= rx;
      rxs    <= sync_q;
    end
  end

  // Oversample position inside the current bit. It is zeroed at start detection
  // and then wraps every OVERSAMPLE ticks, so each bit is sampled one full bit
  // period after the previous one without re-aligning at the start bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (start_det) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= (cnt_q == CW'(OVERSAMPLE - 1)) ? '0 : cnt_q + CW'(1);
    end
  end

  // The sampling strobe is the tick that advances the position counter to the
  // decision tick; cnt_q holds the value before that tick.
`ifdef UART_RX_MAJORITY_EN
  logic maj_a_q;
  logic maj_b_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      maj_a_q <= 1'b1;
      maj_b_q <= 1'b1;
    end else if (tick && cnt_q == CW'(MID - 2)) begin
      maj_a_q <= rxs;
    end else if (tick && cnt_q == CW'(MID - 1)) begin
      maj_b_q <= rxs;
    end
  end

  assign sample_stb = tick && (cnt_q == CW'(MID));
  assign sample_bit = (maj_a_q & maj_b_q) | (maj_a_q & rxs) | (maj_b_q & rxs);
`else
  assign sample_stb = tick && (cnt_q == CW'(MID - 1));
  assign sample_bit = rxs;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first; a path that left one
  // unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    start_det = 1'b0;
    frame_end = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d   = ST_START;
          start_det = 1'b1;
        end
      end
      ST_START: begin
        if (sample_stb) state_d = sample_bit ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (sample_stb && bit_idx_q == 3'd7) state_d = pen_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (sample_stb) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (sample_stb) begin
          frame_end = 1'b1;
          state_d   = sample_bit ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the shift register needs no reset: dout only copies it after all
  // eight bits of a frame have been written, so fewer reset flops.
  always_ff @(posedge clk) begin
    if (state_q == ST_DATA && sample_stb) data_q[bit_idx_q] <= sample_bit;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dout      <= '0;
      valid     <= 1'b0;
      perr      <= 1'b0;
      ferr      <= 1'b0;
      pen_q     <= 1'b0;
      peven_q   <= 1'b0;
      perr_n_q  <= 1'b0;
      stop_q    <= 1'b1;
      done_q    <= 1'b0;
      bit_idx_q <= '0;
    end else begin
      valid  <= 1'b0;
      done_q <= frame_end;
      if (start_det) begin
        pen_q    <= pen;
        peven_q  <= peven;
        perr_n_q <= 1'b0;
      end
      if (state_q == ST_START && sample_stb) bit_idx_q <= '0;
      if (state_q == ST_DATA && sample_stb) bit_idx_q <= bit_idx_q + 3'd1;
      if (state_q == ST_PARITY && sample_stb) begin
        perr_n_q <= (sample_bit != parity_bit(data_q, peven_q));
      end
      if (frame_end) stop_q <= sample_bit;
      // Results are published one clock after the stop sample.
      if (done_q) begin
        dout  <= data_q;
        perr  <= perr_n_q;
        ferr  <= ~stop_q;
        valid <= 1'b1;
      end
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule
